// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C constants, FSM encodings and address helper
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_IGNORE
    } i2c_state_e;

    // Sub-phase of an ACK clock: drive on the fall, hold through the rise, release on the next fall.
    typedef enum logic [1:0] {
        ACK_WAIT_FALL,
        ACK_WAIT_RISE,
        ACK_WAIT_END
    } i2c_ack_phase_e;

    function automatic logic addr_hit(input logic [I2C_BYTE_W-1:0] b,
                                      input logic [I2C_ADDR_W-1:0] a);
        return (b[I2C_BYTE_W-1:1] == a) && (b[0] == I2C_WRITE);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - 2-flop synchronizer plus delayed copy with edge pulses
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic       meta_q;
    logic       sync_q;
    logic       dly_q;
    logic [2:0] vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            dly_q  <= 1'b1;
            vld_q  <= 3'b000;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
            vld_q  <= {vld_q[1:0], 1'b1};
        end
    end

    // Edges are suppressed until the pipe holds real samples, so a line that is
    // low at reset release cannot masquerade as a falling edge.
    assign level_o = sync_q;
    assign rise_o  = vld_q[2] &  sync_q & ~dly_q;
    assign fall_o  = vld_q[2] & ~sync_q &  dly_q;

endmodule

// File: rtl/i2c_rx.sv
// rtl/i2c_rx.sv - write-only I2C target receiver with address match and ACK
module i2c_rx
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] ADDR = 7'h42
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic [I2C_BYTE_W-1:0] data_out,
    output logic                  wr_en,
    output logic                  start_det,
    output logic                  stop_det,
    output logic                  busy
);

    logic scl, scl_rise, scl_fall;
    logic sda, sda_rise, sda_fall;
    logic start_c, stop_c;

    i2c_line_sync u_scl_sync (
        .clk     (clk),
        .rst     (rst),
        .line_i  (scl_in),
        .level_o (scl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk     (clk),
        .rst     (rst),
        .line_i  (sda_in),
        .level_o (sda),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    assign start_c = sda_fall & scl;
    assign stop_c  = sda_rise & scl;

    i2c_state_e            state_q, state_d;
    i2c_ack_phase_e        ack_q, ack_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [I2C_BYTE_W-1:0] shift_q, shift_d;
    logic [I2C_BYTE_W-1:0] data_q, data_d;
    logic                  full_q, full_d;
    logic                  sda_oe_q, sda_oe_d;
    logic                  wr_en_q, wr_en_d;
    logic                  start_q, start_d;
    logic                  stop_q, stop_d;
    logic                  busy_q, busy_d;
    logic [I2C_BYTE_W-1:0] shift_in;

    assign shift_in = {shift_q[I2C_BYTE_W-2:0], sda};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ack_q    <= ACK_WAIT_FALL;
            cnt_q    <= 3'd0;
            shift_q  <= '0;
            data_q   <= '0;
            full_q   <= 1'b0;
            sda_oe_q <= 1'b0;
            wr_en_q  <= 1'b0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            full_q   <= full_d;
            sda_oe_q <= sda_oe_d;
            wr_en_q  <= wr_en_d;
            start_q  <= start_d;
            stop_q   <= stop_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ack_d    = ack_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        data_d   = data_q;
        full_d   = full_q;
        sda_oe_d = sda_oe_q;
        busy_d   = busy_q;
        wr_en_d  = 1'b0;
        start_d  = 1'b0;
        stop_d   = 1'b0;

        if (stop_c) begin
            state_d  = ST_IDLE;
            cnt_d    = 3'd0;
            full_d   = 1'b0;
            sda_oe_d = 1'b0;
            stop_d   = 1'b1;
            busy_d   = 1'b0;
        end else if (start_c) begin
            state_d  = ST_ADDR;
            cnt_d    = 3'd0;
            full_d   = 1'b0;
            sda_oe_d = 1'b0;
            start_d  = 1'b1;
            busy_d   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            ack_d   = ACK_WAIT_FALL;
                            state_d = addr_hit(shift_in, ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                        end
                    end
                end
                ST_DATA: begin
                    // The byte is only handed over on the following SCL fall, so the
                    // strobe and the ACK drive land in the same cycle.
                    if (scl_rise && !full_q) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_q + 3'd1;
                        full_d  = (cnt_q == 3'd7);
                    end else if (scl_fall && full_q) begin
                        data_d   = shift_q;
                        wr_en_d  = 1'b1;
                        sda_oe_d = 1'b1;
                        full_d   = 1'b0;
                        ack_d    = ACK_WAIT_RISE;
                        state_d  = ST_DATA_ACK;
                    end
                end
                ST_ADDR_ACK, ST_DATA_ACK: begin
                    case (ack_q)
                        ACK_WAIT_FALL: if (scl_fall) begin
                            sda_oe_d = 1'b1;
                            ack_d    = ACK_WAIT_RISE;
                        end
                        ACK_WAIT_RISE: if (scl_rise) ack_d = ACK_WAIT_END;
                        default: if (scl_fall) begin
                            sda_oe_d = 1'b0;
                            ack_d    = ACK_WAIT_FALL;
                            state_d  = ST_DATA;
                        end
                    endcase
                end
                ST_IGNORE: sda_oe_d = 1'b0;
                default:   state_d  = ST_IDLE;
            endcase
        end
    end

    assign sda_oe    = sda_oe_q;
    assign data_out  = data_q;
    assign wr_en     = wr_en_q;
    assign start_det = start_q;
    assign stop_det  = stop_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_rx.sv
// tb/tb_i2c_rx.sv - directed bench for i2c_rx driving a modelled I2C master
module tb_i2c_rx;
    import i2c_pkg::*;

    localparam int QC = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_pin;
    logic       sda_oe;
    logic [7:0] data_out;
    logic       wr_en, start_det, stop_det, busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] wr_log[$];
    int start_cyc = 0, start_pulses = 0, stop_cyc = 0, stop_pulses = 0;
    int oe_cyc = 0, busy_low_cyc = 0, wr_oe_bad = 0, busy_bad = 0;
    logic start_prev = 1'b0, stop_prev = 1'b0;

    assign sda_pin = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_rx #(.ADDR(7'h42)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl_m),
        .sda_in    (sda_pin),
        .sda_oe    (sda_oe),
        .data_out  (data_out),
        .wr_en     (wr_en),
        .start_det (start_det),
        .stop_det  (stop_det),
        .busy      (busy)
    );

    always @(negedge clk) begin
        if (wr_en) begin
            wr_log.push_back(data_out);
            if (!sda_oe) wr_oe_bad <= wr_oe_bad + 1;
        end
        if (start_det) start_cyc <= start_cyc + 1;
        if (start_det && !start_prev) start_pulses <= start_pulses + 1;
        if (stop_det) stop_cyc <= stop_cyc + 1;
        if (stop_det && !stop_prev) stop_pulses <= stop_pulses + 1;
        if (sda_oe) oe_cyc <= oe_cyc + 1;
        if (!busy) busy_low_cyc <= busy_low_cyc + 1;
        if ((start_det && !busy) || (stop_det && busy)) busy_bad <= busy_bad + 1;
        start_prev <= start_det;
        stop_prev  <= stop_det;
    end

    task automatic wait_q();
        repeat (QC) @(negedge clk);
    endtask

    task automatic m_start();
        sda_m = 1'b1; scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic m_rstart();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic m_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
        wait_q();
    endtask

    task automatic m_bit(input logic b);
        sda_m = b; wait_q();
        scl_m = 1'b1; wait_q(); wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic m_ack(output logic acked);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        acked = (sda_pin == 1'b0);
        wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic m_byte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) m_bit(b[i]);
        m_ack(acked);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        if (sda_oe !== 1'b0) begin $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); n_fail++; end
        n_checks++;
        if (data_out !== 8'h00) begin $display("FAIL reset_data_out got=%h exp=00", data_out); n_fail++; end
        n_checks++;
        if (wr_en !== 1'b0) begin $display("FAIL reset_wr_en got=%b exp=0", wr_en); n_fail++; end
        n_checks++;
        if ({start_det, stop_det} !== 2'b00) begin $display("FAIL reset_det got=%b exp=00", {start_det, stop_det}); n_fail++; end
        n_checks++;
        if (busy !== 1'b0) begin $display("FAIL reset_busy got=%b exp=0", busy); n_fail++; end
        n_checks++;
        rst = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_write();
        logic a0, a1;
        int w0, s0, sc0, p0, pc0, o0;
        w0 = wr_log.size(); s0 = start_pulses; sc0 = start_cyc; p0 = stop_pulses; pc0 = stop_cyc; o0 = oe_cyc;
        m_start();
        m_byte(8'h84, a0);
        m_byte(8'h55, a1);
        m_stop();
        if ({a0, a1} !== 2'b11) begin $display("FAIL write_acks got=%b exp=11", {a0, a1}); n_fail++; end
        n_checks++;
        if (wr_log.size() - w0 !== 1) begin $display("FAIL write_wr_count got=%0d exp=1", wr_log.size() - w0); n_fail++; end
        else begin
            if (wr_log[w0] !== 8'h55) begin $display("FAIL write_byte got=%h exp=55", wr_log[w0]); n_fail++; end
            n_checks++;
        end
        n_checks++;
        if (data_out !== 8'h55) begin $display("FAIL write_data_hold got=%h exp=55", data_out); n_fail++; end
        n_checks++;
        if (start_pulses - s0 !== 1 || start_cyc - sc0 !== 1) begin
            $display("FAIL write_start_pulse got=%0d/%0d exp=1/1", start_pulses - s0, start_cyc - sc0); n_fail++;
        end
        n_checks++;
        if (stop_pulses - p0 !== 1 || stop_cyc - pc0 !== 1) begin
            $display("FAIL write_stop_pulse got=%0d/%0d exp=1/1", stop_pulses - p0, stop_cyc - pc0); n_fail++;
        end
        n_checks++;
        if (oe_cyc - o0 == 0) begin $display("FAIL write_oe_seen got=0 exp=nonzero"); n_fail++; end
        n_checks++;
        if (busy !== 1'b0) begin $display("FAIL write_busy_after_stop got=%b exp=0", busy); n_fail++; end
        n_checks++;
    endtask

    task automatic test_wrong_addr();
        logic a0, a1;
        int w0, o0, b0, b1;
        w0 = wr_log.size(); o0 = oe_cyc;
        m_start();
        b0 = busy_low_cyc;
        m_byte(8'h86, a0);
        m_byte(8'hAA, a1);
        b1 = busy_low_cyc;
        m_stop();
        if ({a0, a1} !== 2'b00) begin $display("FAIL wrong_acks got=%b exp=00", {a0, a1}); n_fail++; end
        n_checks++;
        if (oe_cyc - o0 !== 0) begin $display("FAIL wrong_oe got=%0d exp=0", oe_cyc - o0); n_fail++; end
        n_checks++;
        if (wr_log.size() - w0 !== 0) begin $display("FAIL wrong_wr got=%0d exp=0", wr_log.size() - w0); n_fail++; end
        n_checks++;
        if (b1 - b0 !== 0) begin $display("FAIL wrong_busy_low got=%0d exp=0", b1 - b0); n_fail++; end
        n_checks++;
    endtask

    task automatic test_read_req();
        logic a0, a1;
        int w0, o0;
        w0 = wr_log.size(); o0 = oe_cyc;
        m_start();
        m_byte(8'h85, a0);
        if (dut.state_q !== ST_IGNORE) begin $display("FAIL read_state got=%0d exp=%0d", dut.state_q, ST_IGNORE); n_fail++; end
        n_checks++;
        m_byte(8'h00, a1);
        m_stop();
        if ({a0, a1} !== 2'b00) begin $display("FAIL read_acks got=%b exp=00", {a0, a1}); n_fail++; end
        n_checks++;
        if (oe_cyc - o0 !== 0 || wr_log.size() - w0 !== 0) begin
            $display("FAIL read_activity got=oe%0d/wr%0d exp=0/0", oe_cyc - o0, wr_log.size() - w0); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_back_to_back();
        logic a0, a1, a2, a3;
        int w0, s0, b0, b1;
        w0 = wr_log.size(); s0 = start_pulses;
        m_start();
        b0 = busy_low_cyc;
        m_byte(8'h84, a0);
        m_byte(8'h12, a1);
        m_rstart();
        m_byte(8'h84, a2);
        m_byte(8'h34, a3);
        b1 = busy_low_cyc;
        m_stop();
        if ({a0, a1, a2, a3} !== 4'b1111) begin $display("FAIL b2b_acks got=%b exp=1111", {a0, a1, a2, a3}); n_fail++; end
        n_checks++;
        if (wr_log.size() - w0 !== 2) begin $display("FAIL b2b_wr_count got=%0d exp=2", wr_log.size() - w0); n_fail++; end
        else begin
            if (wr_log[w0] !== 8'h12 || wr_log[w0+1] !== 8'h34) begin
                $display("FAIL b2b_bytes got=%h,%h exp=12,34", wr_log[w0], wr_log[w0+1]); n_fail++;
            end
            n_checks++;
        end
        n_checks++;
        if (start_pulses - s0 !== 2) begin $display("FAIL b2b_starts got=%0d exp=2", start_pulses - s0); n_fail++; end
        n_checks++;
        if (b1 - b0 !== 0) begin $display("FAIL b2b_busy_low got=%0d exp=0", b1 - b0); n_fail++; end
        n_checks++;
    endtask

    task automatic test_partial_byte();
        logic a0, a1;
        int w0;
        w0 = wr_log.size();
        m_start();
        m_byte(8'h84, a0);
        m_bit(1'b1); m_bit(1'b0); m_bit(1'b1); m_bit(1'b1);
        m_stop();
        if (wr_log.size() - w0 !== 0) begin $display("FAIL partial_wr got=%0d exp=0", wr_log.size() - w0); n_fail++; end
        n_checks++;
        if (data_out !== 8'h34) begin $display("FAIL partial_data_out got=%h exp=34", data_out); n_fail++; end
        n_checks++;
        if (dut.state_q !== ST_IDLE || busy !== 1'b0) begin
            $display("FAIL partial_idle got=state%0d/busy%b exp=%0d/0", dut.state_q, busy, ST_IDLE); n_fail++;
        end
        n_checks++;
        w0 = wr_log.size();
        m_start();
        m_byte(8'h84, a0);
        m_byte(8'hC3, a1);
        m_stop();
        if ({a0, a1} !== 2'b11 || wr_log.size() - w0 !== 1 || data_out !== 8'hC3) begin
            $display("FAIL partial_next got=ack%b/wr%0d/data%h exp=11/1/c3", {a0, a1}, wr_log.size() - w0, data_out); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_reset_mid_ack();
        logic a0, a1;
        int w0;
        m_start();
        m_byte(8'h84, a0);
        for (int i = 7; i >= 0; i--) m_bit(1'(8'h77 >> i));
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        if (sda_oe !== 1'b1) begin $display("FAIL rstack_pre_oe got=%b exp=1", sda_oe); n_fail++; end
        n_checks++;
        rst = 1'b1;
        #1;
        if (sda_oe !== 1'b0) begin $display("FAIL rstack_oe got=%b exp=0", sda_oe); n_fail++; end
        n_checks++;
        if ({data_out, wr_en, start_det, stop_det, busy} !== 12'h000) begin
            $display("FAIL rstack_outputs got=%h/%b%b%b%b exp=00/0000", data_out, wr_en, start_det, stop_det, busy); n_fail++;
        end
        n_checks++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_q();
        scl_m = 1'b0; wait_q();
        m_stop();
        w0 = wr_log.size();
        m_start();
        m_byte(8'h84, a0);
        m_byte(8'h5A, a1);
        m_stop();
        if ({a0, a1} !== 2'b11) begin $display("FAIL rstack_next_acks got=%b exp=11", {a0, a1}); n_fail++; end
        n_checks++;
        if (wr_log.size() - w0 !== 1 || data_out !== 8'h5A) begin
            $display("FAIL rstack_next_byte got=wr%0d/data%h exp=1/5a", wr_log.size() - w0, data_out); n_fail++;
        end
        n_checks++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_wrong_addr();
        test_read_req();
        test_back_to_back();
        test_partial_byte();
        test_reset_mid_ack();
        if (wr_oe_bad != 0) begin $display("FAIL wr_en_without_oe got=%0d exp=0", wr_oe_bad); n_fail++; end
        n_checks++;
        if (busy_bad != 0) begin $display("FAIL busy_vs_det got=%0d exp=0", busy_bad); n_fail++; end
        n_checks++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
